// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// holding each result until the pipeline advances and driving the global stall.
module mem_port_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ok_o,
  input  logic        dm_rd_i,
  input  logic        dm_wr_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  input  logic [3:0]  dm_be_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ok_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SERVE_IF = 2'b01,
    SERVE_DM = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        if_ok_q, if_ok_d;
  logic        dm_ok_q, dm_ok_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [CW-1:0] wcnt_q, wcnt_d;

  logic dm_req_s;
  logic stall_s;

  assign dm_req_s = dm_rd_i | dm_wr_i;
  assign stall_s  = (if_req_i & ~if_ok_q) | (dm_req_s & ~dm_ok_q);

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      if_ok_q     <= 1'b0;
      dm_ok_q     <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      dm_rdata_q  <= 32'h0000_0000;
      bus_err_q   <= 1'b0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ok_q     <= if_ok_d;
      dm_ok_q     <= dm_ok_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
      wcnt_q      <= wcnt_d;
    end
  end

  // Next-state: grant in IDLE (data side first), complete or abort in SERVE
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ok_d     = if_ok_q;
    dm_ok_d     = dm_ok_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = bus_err_q;
    wcnt_d      = wcnt_q;

    // The pipeline advances on this edge, so the next cycle starts fresh.
    if (!stall_s) begin
      if_ok_d = 1'b0;
      dm_ok_d = 1'b0;
    end else begin
      if_ok_d = if_ok_q;
      dm_ok_d = dm_ok_q;
    end

    case (state_q)
      IDLE: begin
        if (dm_req_s && !dm_ok_q) begin
          state_d     = SERVE_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_wr_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          mem_be_d    = dm_wr_i ? dm_be_i : 4'b1111;
          wcnt_d      = '0;
        end else if (if_req_i && !if_ok_q) begin
          state_d     = SERVE_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = 32'h0000_0000;
          mem_be_d    = 4'b1111;
          wcnt_d      = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_IF: begin
        if (mem_ack_i) begin
          if_rdata_d = mem_rdata_i;
          if_ok_d    = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else if (wcnt_q == WAIT_LAST) begin
          if_rdata_d = ERR_DATA;
          if_ok_d    = 1'b1;
          bus_err_d  = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      SERVE_DM: begin
        if (mem_ack_i) begin
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
          dm_ok_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else if (wcnt_q == WAIT_LAST) begin
          // Aborted stores keep the last load result.
          if (!mem_we_q) begin
            dm_rdata_d = ERR_DATA;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
          dm_ok_d   = 1'b1;
          bus_err_d = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_ok_o     = if_ok_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign dm_ok_o     = dm_ok_q;
  assign stall_o     = stall_s;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed pipeline scenarios, a memory
// responder, and a monitor that checks every bus request and every completion.
module tb_mem_port_arbiter;

  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ok;
  logic        dm_rd, dm_wr;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_ok;
  logic        stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
    logic        berr;
  } resp_t;

  mreq_t mreq_q[$];
  resp_t resp_q[$];

  // responder controls
  bit ack_en    = 1'b1;
  int ack_delay = 0;
  bit force_ack = 1'b0;

  mem_port_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ok_o(if_ok),
    .dm_rd_i(dm_rd), .dm_wr_i(dm_wr), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_be_i(dm_be), .dm_rdata_o(dm_rdata), .dm_ok_o(dm_ok),
    .stall_o(stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .bus_err_o(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_3000: mem_model = 32'h2008_0005;
      32'h0000_3004: mem_model = 32'h8C09_0010;
      32'h0000_0010: mem_model = 32'h1234_5678;
      default:       mem_model = a ^ 32'hCAFE_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_m(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd);
    mreq_t m;
    m.addr = a; m.we = we; m.be = be; m.wdata = wd;
    mreq_q.push_back(m);
  endtask

  task automatic push_r(input logic is_dm, input logic [31:0] d, input logic berr);
    resp_t r;
    r.is_dm = is_dm; r.data = d; r.berr = berr;
    resp_q.push_back(r);
  endtask

  // Counts stall cycles starting at the current cycle; ends at the negedge with stall=0.
  task automatic run_stall(output int n);
    bit done;
    done = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n++;
      @(posedge clk);
      #1;
    end
    if (!done) chk("stall_bound", 32'd1, 32'd0);
  endtask

  // Memory responder: acks ack_delay cycles after mem_req rises, or once on demand.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0000_0000;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        force_ack = 1'b0;
      end else if (mem_req && ack_en) begin
        if (cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model(mem_addr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares each new bus request and each completion against the queues.
  initial begin
    logic req_p, if_p, dm_p;
    mreq_t m;
    resp_t r;
    req_p = 1'b0; if_p = 1'b0; dm_p = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !req_p) begin
        if (mreq_q.size() == 0) begin
          chk("unexpected_mem_req", mem_addr, 32'hFFFF_FFFF);
        end else begin
          m = mreq_q.pop_front();
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (dm_ok && !dm_p) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_dm_ok", dm_rdata, 32'hFFFF_FFFF);
        end else begin
          r = resp_q.pop_front();
          chk("resp_port_dm", {31'd0, r.is_dm}, 32'd1);
          chk("dm_rdata", dm_rdata, r.data);
          chk("dm_bus_err", {31'd0, bus_err}, {31'd0, r.berr});
        end
      end
      if (if_ok && !if_p) begin
        if (resp_q.size() == 0) begin
          chk("unexpected_if_ok", if_rdata, 32'hFFFF_FFFF);
        end else begin
          r = resp_q.pop_front();
          chk("resp_port_if", {31'd0, r.is_dm}, 32'd0);
          chk("if_rdata", if_rdata, r.data);
          chk("if_bus_err", {31'd0, bus_err}, {31'd0, r.berr});
        end
      end
      req_p = mem_req; if_p = if_ok; dm_p = dm_ok;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_rd = 1'b0; dm_wr = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_oks", {30'd0, if_ok, dm_ok}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_stall", {31'd0, stall}, 32'd0);

    // 1) lone fetch
    if_req = 1'b1; if_addr = 32'h0000_3000;
    push_m(32'h0000_3000, 1'b0, 4'b1111, 32'h0);
    push_r(1'b0, 32'h2008_0005, 1'b0);
    @(negedge clk);
    chk("t1_c0_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("t1_c1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_c1_stall", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("t1_c2_if_ok", {31'd0, if_ok}, 32'd1);
    chk("t1_c2_stall", {31'd0, stall}, 32'd0);
    chk("t1_c2_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_c3_if_ok", {31'd0, if_ok}, 32'd0);
    tick();

    // 2) fetch and load together: load served first
    if_req = 1'b1; if_addr = 32'h0000_3004;
    dm_rd = 1'b1; dm_addr = 32'h0000_0010;
    push_m(32'h0000_0010, 1'b0, 4'b1111, 32'h0);
    push_r(1'b1, 32'h1234_5678, 1'b0);
    push_m(32'h0000_3004, 1'b0, 4'b1111, 32'h0);
    push_r(1'b0, 32'h8C09_0010, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    @(negedge clk);
    chk("t2_c3_dm_ok_hold", {30'd0, dm_ok, if_ok}, 32'd2);
    chk("t2_c3_stall", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("t2_c4_both_ok", {30'd0, dm_ok, if_ok}, 32'd3);
    chk("t2_c4_stall", {31'd0, stall}, 32'd0);
    tick();
    if_req = 1'b0; dm_rd = 1'b0;
    tick();

    // 3) store
    dm_wr = 1'b1; dm_addr = 32'h0000_0020; dm_wdata = 32'hAABB_CCDD; dm_be = 4'b0011;
    push_m(32'h0000_0020, 1'b1, 4'b0011, 32'hAABB_CCDD);
    push_r(1'b1, 32'h1234_5678, 1'b0);
    run_stall(n);
    chk("t3_stall_cycles", n, 32'd2);
    tick();
    dm_wr = 1'b0; dm_be = 4'b0000;
    tick();

    // 4) load that times out, then a stray ack
    ack_en = 1'b0;
    dm_rd = 1'b1; dm_addr = 32'h0000_0040;
    push_m(32'h0000_0040, 1'b0, 4'b1111, 32'h0);
    push_r(1'b1, ERRD, 1'b1);
    run_stall(n);
    chk("t4_stall_cycles", n, TO + 1);
    chk("t4_mem_req_drop", {31'd0, mem_req}, 32'd0);
    force_ack = 1'b1;
    tick();
    dm_rd = 1'b0;
    ack_en = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_stray_rdata", dm_rdata, ERRD);
    chk("t4_stray_ok", {30'd0, dm_ok, mem_req}, 32'd0);
    chk("t4_bus_err_sticky", {31'd0, bus_err}, 32'd1);
    tick();

    // 5) reset in the middle of a load
    ack_delay = 1;
    dm_rd = 1'b1; dm_addr = 32'h0000_0050;
    push_m(32'h0000_0050, 1'b0, 4'b1111, 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_c1_mem_req", {31'd0, mem_req}, 32'd1);
    force_ack = 1'b1;
    tick();
    rst = 1'b0; dm_rd = 1'b0; ack_delay = 0;
    @(negedge clk);
    chk("t5_ack_seen", {31'd0, mem_ack}, 32'd1);
    chk("t5_after_rst", {29'd0, mem_req, dm_ok, if_ok}, 32'd0);
    chk("t5_bus_err_clr", {31'd0, bus_err}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_ack_ignored", {30'd0, dm_ok, mem_req}, 32'd0);
    chk("t5_dm_rdata", dm_rdata, 32'd0);
    tick();

    // 6) back-to-back fetches
    if_req = 1'b1; if_addr = 32'h0000_3000;
    push_m(32'h0000_3000, 1'b0, 4'b1111, 32'h0);
    push_r(1'b0, 32'h2008_0005, 1'b0);
    run_stall(n);
    chk("t6_first_stall", n, 32'd2);
    tick();
    if_addr = 32'h0000_3004;
    push_m(32'h0000_3004, 1'b0, 4'b1111, 32'h0);
    push_r(1'b0, 32'h8C09_0010, 1'b0);
    @(negedge clk);
    chk("t6_c3_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_c3_stall", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("t6_c4_mem_addr", mem_addr, 32'h0000_3004);
    tick();
    @(negedge clk);
    chk("t6_c5_if_ok", {31'd0, if_ok}, 32'd1);
    tick();
    if_req = 1'b0;
    repeat (3) tick();

    chk("mreq_q_empty", mreq_q.size(), 32'd0);
    chk("resp_q_empty", resp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
